// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory port between ibus and dbus requesters.
// Ports: clk, reset (async active-low); ibus i_valid/i_addr/i_size -> i_addr_ok/i_data_ok/i_rdata;
// dbus d_valid/d_addr/d_size/d_strobe/d_wdata -> d_addr_ok/d_data_ok/d_rdata;
// downstream m_valid/m_addr/m_size/m_strobe/m_wdata (registered) <- m_addr_ok/m_data_ok/m_rdata.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed dbus priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_size,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_size,
  input  logic [STRB_W-1:0] d_strobe,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [2:0]        m_size,
  output logic [STRB_W-1:0] m_strobe,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, nxt;
  logic own_d, grant_d, start, acc, done;
  assign start = (state == IDLE) & (i_valid | d_valid);
`ifdef MEM_ARB_RR_EN
  logic last_d;
  // On a conflict the side not granted last wins.
  assign grant_d = d_valid & (~i_valid | ~last_d);
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_d <= 1'b0;
    else if (start) last_d <= grant_d;
`else
  assign grant_d = d_valid;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      own_d    <= 1'b0;
      m_addr   <= '0;
      m_size   <= '0;
      m_strobe <= '0;
      m_wdata  <= '0;
    end else begin
      state <= nxt;
      if (start) begin
        own_d    <= grant_d;
        m_addr   <= grant_d ? d_addr : i_addr;
        m_size   <= grant_d ? d_size : i_size;
        m_strobe <= grant_d ? d_strobe : '0;
        m_wdata  <= grant_d ? d_wdata : '0;
      end
    end
  always_comb begin
    nxt = state;
    if (start) nxt = REQ;
    else if (state == REQ && m_addr_ok) nxt = m_data_ok ? IDLE : WAIT;
    else if (state == WAIT && m_data_ok) nxt = IDLE;
    m_valid   = state == REQ;
    acc       = m_valid & m_addr_ok;
    done      = (acc & m_data_ok) | ((state == WAIT) & m_data_ok);
    i_addr_ok = acc & ~own_d;
    d_addr_ok = acc & own_d;
    i_data_ok = done & ~own_d;
    d_data_ok = done & own_d;
    i_rdata   = i_data_ok ? m_rdata : '0;
    d_rdata   = d_data_ok ? m_rdata : '0;
  end
endmodule
